sd4_mac_seq_ctrl: RTL and testbench
===================================

Name: sd4_mac_seq_ctrl

Overview:
Sequencing controller for the SD4 (radix-4 Booth) MAC pipeline: booth/pp stage, alignment stage, adder-tree register stage.
- Accepts a dot-product job of cfg_len operand pairs and meters operand issue into the pipeline with a valid/ready handshake.
- Tracks in-flight items through the fixed-latency pipeline and accumulates the 20-bit signed adder-tree sum for each retired item.
- Presents the final accumulated result on a valid/ready output port.

Parameters:
PIPE_DEPTH, 3, register stages from operand acceptance to signed_sum valid
LEN_W, 8, width of the job length field
SUM_W, 20, width of the incoming adder-tree sum
ACC_W, 28, accumulator/result width, must be >= SUM_W

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
start  input  1  job start pulse, sampled in IDLE only
cfg_len  input  LEN_W  number of operand pairs in the job, sampled with start
busy  output  1  high in RUN, DRAIN and HOLD
in_valid  input  1  operand pair presented to pipeline stage 1
in_ready  output  1  controller accepts operand this cycle
stage_en  output  1  clock-enable to all pipeline stage registers
sum_in  input  SUM_W  signed_sum from the adder-tree register stage
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_acc  output  ACC_W  signed accumulated result

Behaviour:
- Reset (asynchronous, rst=0): the following clear immediately and hold while reset is low:
  - state=IDLE;
  - all counters, the vld shift register and acc cleared to 0;
  - busy=0, in_ready=0, stage_en=0, out_valid=0, out_acc=0.
- Reset mid-job aborts the job. No partial result is emitted.
- FSM states: IDLE, RUN, DRAIN, HOLD.
- IDLE:
  - start=1 latches len=cfg_len, clears acc, issued and retired.
  - If cfg_len=0, next state is HOLD (out_valid=1, out_acc=0 on the next cycle). Otherwise next state is RUN.
- RUN:
  - in_ready = (issued < len).
  - Accept = in_valid & in_ready; each accept increments issued.
  - When the accept that makes issued==len occurs, next state is DRAIN.
- DRAIN:
  - in_ready=0.
  - When the retire that makes retired==len occurs, next state is HOLD.
  - The retire and the RUN->DRAIN transition may occur in the same cycle. The transitions are independent. If both complete together, next state is HOLD directly.
- HOLD:
  - out_valid=1 and out_acc=acc, held stable until out_valid & out_ready.
  - On that handshake, next state is IDLE; out_valid drops the following cycle.
  - in_ready=0 throughout HOLD.
- start outside IDLE is ignored. cfg_len is only sampled with an accepted start.
- stage_en = 1 in RUN and DRAIN, 0 in IDLE and HOLD. The pipeline never holds live data in IDLE or HOLD.
- Valid tracking:
  - vld[0] <= accept; vld[k] <= vld[k-1].
  - Shifting happens only while stage_en=1; vld is cleared on entry to IDLE.
- Retire and latency:
  - Retire happens on a cycle with vld[PIPE_DEPTH-1]=1 and stage_en=1.
  - On retire, acc <= acc + sign_extend(sum_in) and retired increments.
  - An operand accepted in cycle t retires in cycle t+PIPE_DEPTH.
  - out_valid rises the cycle after the last retire.
- Arithmetic: two's complement. Without the optional feature, acc wraps modulo 2^ACC_W.
- Bubbles (in_valid=0 in RUN) propagate as vld=0 entries. They do not count and do not accumulate.
- Counters are LEN_W+1 bits so that len = 2^LEN_W-1 cannot wrap.

Optional Feature:
Macro: SD4_MAC_SAT_EN
- Defined:
  - Accumulation saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Adds output port out_ovf (1 bit), a sticky per-job flag set on any saturating add.
  - out_ovf is valid with out_valid, cleared on start and on reset.
- Undefined: acc wraps, and port out_ovf does not exist.

Decomposition:
- Shared package sd4_mac_pkg holds:
  - FSM state typedef (IDLE, RUN, DRAIN, HOLD);
  - constants PIPE_DEPTH=3 and SUM_W=20, shared with the pipeline stages.
- One natural sub-module: sd4_mac_acc, the sign-extending accumulator with optional saturation, an add-enable and a clear input. The FSM, counters and vld shift register stay in the top.

Test Plan:
1. Assert rst=0 mid-cycle with clk running -> every output is 0 immediately, before the next edge. Release -> IDLE, in_ready=0.
2. cfg_len=3, start, in_valid held 1, bench pipeline model returns sum_in 100, -30, 5 at t+3 -> in_ready high 3 cycles then 0; out_valid one cycle after 3rd retire; out_acc=75; busy low after handshake.
3. cfg_len=0, start -> out_valid=1 next cycle with out_acc=0, stage_en never asserted.
4. cfg_len=2, in_valid pattern 1,0,0,1 -> issued=2 only after 4th cycle; bubbles do not accumulate; sum_in -7 and -9 -> out_acc=-16.
5. out_ready held 0 for 5 cycles in HOLD, start pulsed -> out_valid and out_acc stable, start ignored, stage_en=0; out_ready=1 -> IDLE next cycle.
6. ACC_W=20, cfg_len=2, sum_in 0x7FFFF twice -> without SD4_MAC_SAT_EN out_acc=0xFFFFE (wrapped); with it, out_acc=0x7FFFF and out_ovf=1. Next job -> out_ovf cleared at start.

Source files
------------

// File: rtl/sd4_mac_pkg.sv
// Shared definitions for the SD4 MAC sequencing controller and the pipeline
// stages it drives: FSM state encoding and the fixed pipeline geometry.
// Optional feature macro used by this slice: SD4_MAC_SAT_EN.
package sd4_mac_pkg;

    // Register stages from operand acceptance to a valid signed_sum
    localparam int PIPE_DEPTH = 3;
    // Width of the adder-tree signed_sum
    localparam int SUM_W      = 20;

    // FSM state encoding kept as plain constants for legacy compatibility
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t DRAIN = 2'd2;
    localparam state_t HOLD  = 2'd3;

endpackage

// File: rtl/sd4_mac_seq_ctrl_if.sv
// Job, operand-issue and result signals between the SD4 MAC sequencing
// controller (slave) and its job source / pipeline / consumer (master).
// Port out_ovf exists only when SD4_MAC_SAT_EN is defined.
interface sd4_mac_seq_ctrl_if #(
    parameter int LEN_W = 8,
    parameter int SUM_W = sd4_mac_pkg::SUM_W,
    parameter int ACC_W = 28
);

    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic             stage_en;
    logic [SUM_W-1:0] sum_in;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
`ifdef SD4_MAC_SAT_EN
    logic             out_ovf;
`endif

    modport master (
        output start, cfg_len, in_valid, sum_in, out_ready,
`ifdef SD4_MAC_SAT_EN
        input  out_ovf,
`endif
        input  busy, in_ready, stage_en, out_valid, out_acc
    );

    modport slave (
        input  start, cfg_len, in_valid, sum_in, out_ready,
`ifdef SD4_MAC_SAT_EN
        output out_ovf,
`endif
        output busy, in_ready, stage_en, out_valid, out_acc
    );

endinterface

// File: rtl/sd4_mac_acc.sv
// Sign-extending accumulator for retired adder-tree sums.
// Wraps modulo 2^ACC_W by default; with SD4_MAC_SAT_EN defined it saturates to
// the signed ACC_W range and keeps a sticky overflow flag until clr or reset.
module sd4_mac_acc #(
    parameter int SUM_W = sd4_mac_pkg::SUM_W,
    parameter int ACC_W = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add_en,
    input  logic [SUM_W-1:0] sum_in,
    output logic [ACC_W-1:0] acc
`ifdef SD4_MAC_SAT_EN
    ,
    output logic             ovf
`endif
);

    logic [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0] acc_nxt;

    assign sum_ext = ACC_W'($signed(sum_in));

`ifdef SD4_MAC_SAT_EN
    logic [ACC_W:0] wide;
    logic           sat_hi;
    logic           sat_lo;

    // One guard bit: top two bits disagreeing means the signed add left the range
    always_comb begin
        wide    = {acc[ACC_W-1], acc} + {sum_ext[ACC_W-1], sum_ext};
        sat_hi  = (wide[ACC_W:ACC_W-1] == 2'b01);
        sat_lo  = (wide[ACC_W:ACC_W-1] == 2'b10);
        acc_nxt = wide[ACC_W-1:0];
        if (sat_hi)
            acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
        else if (sat_lo)
            acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
    end

    // Sticky per-job overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ovf <= 1'b0;
        else if (clr)
            ovf <= 1'b0;
        else if (add_en && (sat_hi || sat_lo))
            ovf <= 1'b1;
    end
`else
    // Plain two's-complement wrap
    always_comb begin
        acc_nxt = acc + sum_ext;
    end
`endif

    // Accumulator register: clear at job start, add on each retire
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (add_en)
            acc <= acc_nxt;
    end

endmodule

// File: rtl/sd4_mac_seq_ctrl.sv
// SD4 (radix-4 Booth) MAC sequencing controller: meters a job of cfg_len
// operand pairs into the fixed-latency pipeline, tracks in-flight items,
// accumulates retired sums and holds the result on a valid/ready port.
// Optional saturation + out_ovf port: define SD4_MAC_SAT_EN.
module sd4_mac_seq_ctrl #(
    parameter int PIPE_DEPTH = sd4_mac_pkg::PIPE_DEPTH,
    parameter int LEN_W      = 8,
    parameter int SUM_W      = sd4_mac_pkg::SUM_W,
    parameter int ACC_W      = 28
) (
    input logic               clk,
    input logic               rst,
    sd4_mac_seq_ctrl_if.slave bus
);

    import sd4_mac_pkg::*;

    localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W:0]   len;
    logic [LEN_W:0]   issued;
    logic [LEN_W:0]   retired;
    logic [PIPE_DEPTH-1:0] vld;
    logic [PIPE_DEPTH-1:0] vld_shift;
    logic             job_start;
    logic             accept;
    logic             retire;
    logic             issue_last;
    logic             retire_last;
    logic             out_hs;
    logic [ACC_W-1:0] acc;

    assign job_start   = (state == IDLE) && bus.start;
    assign bus.in_ready  = (state == RUN) && (issued < len);
    assign bus.stage_en  = (state == RUN) || (state == DRAIN);
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = (state == HOLD);
    assign bus.out_acc   = acc;

    assign accept      = bus.in_valid && bus.in_ready;
    assign retire      = vld[PIPE_DEPTH-1] && bus.stage_en;
    assign issue_last  = accept && ((issued + ONE) == len);
    assign retire_last = retire && ((retired + ONE) == len);
    assign out_hs      = (state == HOLD) && bus.out_ready;

    // Next state; last issue and last retire are independent, both may land together
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = (bus.cfg_len == '0) ? HOLD : RUN;
            end
            RUN: begin
                if (issue_last)
                    state_nxt = retire_last ? HOLD : DRAIN;
            end
            DRAIN: begin
                if (retire_last)
                    state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Valid shift register input: new accept enters stage 0, others move one stage
    always_comb begin
        vld_shift    = '0;
        vld_shift[0] = accept;
        for (int unsigned k = 1; k < unsigned'(PIPE_DEPTH); k++)
            vld_shift[k] = vld[k-1];
    end

    // State register and job length / issue / retire counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            len     <= '0;
            issued  <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            if (job_start) begin
                len     <= {1'b0, bus.cfg_len};
                issued  <= '0;
                retired <= '0;
            end else begin
                if (accept)
                    issued <= issued + ONE;
                if (retire)
                    retired <= retired + ONE;
            end
        end
    end

    // In-flight tracking: shifts with the pipeline clock-enable, flushed on return to IDLE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            vld <= '0;
        else if (out_hs)
            vld <= '0;
        else if (bus.stage_en)
            vld <= vld_shift;
    end

`ifdef SD4_MAC_SAT_EN
    logic ovf;
    assign bus.out_ovf = ovf;
`endif

    sd4_mac_acc #(
        .SUM_W (SUM_W),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk    (clk),
        .rst    (rst),
        .clr    (job_start),
        .add_en (retire),
        .sum_in (bus.sum_in),
        .acc    (acc)
`ifdef SD4_MAC_SAT_EN
        ,
        .ovf    (ovf)
`endif
    );

endmodule

// File: tb/tb_sd4_mac_seq_ctrl.sv
// Scoreboard bench for sd4_mac_seq_ctrl with ACC_W=20 so wrap/saturation is
// reachable from 20-bit sums. Expected results honour SD4_MAC_SAT_EN.
module tb_sd4_mac_seq_ctrl;

    localparam int LEN_W = 8;
    localparam int SUM_W = 20;
    localparam int ACC_W = 20;
    localparam int PD    = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sd4_mac_seq_ctrl_if #(.LEN_W(LEN_W), .SUM_W(SUM_W), .ACC_W(ACC_W)) bus();

    sd4_mac_seq_ctrl #(
        .PIPE_DEPTH (PD),
        .LEN_W      (LEN_W),
        .SUM_W      (SUM_W),
        .ACC_W      (ACC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Pipeline model: operand value accepted in cycle t appears on sum_in in t+PD
    logic [SUM_W-1:0] op_val;
    logic [SUM_W-1:0] pv [PD];
    logic [PD-1:0]    pvld;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pvld <= '0;
        end else if (bus.stage_en) begin
            pvld  <= {pvld[PD-2:0], bus.in_valid & bus.in_ready};
            pv[0] <= op_val;
            for (int k = 1; k < PD; k++) pv[k] <= pv[k-1];
        end
    end

    // Non-retiring slots carry junk so an erroneous add is visible
    assign bus.sum_in = pvld[PD-1] ? pv[PD-1] : 20'h5A5A5;

    typedef struct {
        logic [ACC_W-1:0] acc;
        logic             ovf;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [ACC_W-1:0] a, input logic o);
        exp_t e;
        e.acc = a;
        e.ovf = o;
        sb.push_back(e);
    endtask

    // Result monitor: every output handshake must match the oldest expectation
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none", bus.out_acc);
                end else begin
                    e = sb.pop_front();
                    chk("out_acc", 32'(bus.out_acc), 32'(e.acc));
`ifdef SD4_MAC_SAT_EN
                    chk("out_ovf", 32'(bus.out_ovf), 32'(e.ovf));
`endif
                end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len);
        bus.start   = 1'b1;
        bus.cfg_len = LEN_W'(len);
        cyc();
        bus.start   = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            cyc();
            n++;
        end
        if (!bus.out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got 0 expected 1 within 20 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pat[4];
        logic [SUM_W-1:0] vals[4];

        bus.start     = 1'b0;
        bus.cfg_len   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        op_val        = '0;
        fork
            monitor();
        join_none

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",      32'(bus.busy),      0);
        chk("rst_in_ready",  32'(bus.in_ready),  0);
        chk("rst_stage_en",  32'(bus.stage_en),  0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_acc",   32'(bus.out_acc),   0);
        rst = 1'b1;
        cyc();
        cyc();

        // 1: reset mid-job aborts; outputs drop before the next edge
        start_job(3);
        bus.in_valid = 1'b1;
        op_val       = SUM_W'(11);
        cyc();
        cyc();
        chk("abort_busy_pre", 32'(bus.busy), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_busy",      32'(bus.busy),      0);
        chk("abort_in_ready",  32'(bus.in_ready),  0);
        chk("abort_stage_en",  32'(bus.stage_en),  0);
        chk("abort_out_valid", 32'(bus.out_valid), 0);
        chk("abort_out_acc",   32'(bus.out_acc),   0);
        bus.in_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        chk("post_rst_in_ready", 32'(bus.in_ready), 0);
        chk("post_rst_busy",     32'(bus.busy),     0);

        // 2: three operands back to back, 100 - 30 + 5 = 75
        push(ACC_W'(75), 1'b0);
        start_job(3);
        vals[0] = SUM_W'(100);
        vals[1] = SUM_W'(-30);
        vals[2] = SUM_W'(5);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op_val = vals[i];
            chk("t2_in_ready_run", 32'(bus.in_ready), 1);
            cyc();
        end
        bus.in_valid = 1'b0;
        chk("t2_in_ready_drain", 32'(bus.in_ready),  0);
        chk("t2_stage_en_drain", 32'(bus.stage_en),  1);
        cyc();
        chk("t2_out_valid_c4",   32'(bus.out_valid), 0);
        cyc();
        chk("t2_out_valid_c5",   32'(bus.out_valid), 0);
        cyc();
        chk("t2_out_valid_c6",   32'(bus.out_valid), 1);
        chk("t2_out_acc",        32'(bus.out_acc),   32'h0004B);
        cyc();
        chk("t2_busy_after",     32'(bus.busy),      0);
        chk("t2_out_valid_after", 32'(bus.out_valid), 0);

        // 3: zero-length job goes straight to HOLD with acc 0
        push('0, 1'b0);
        bus.start   = 1'b1;
        bus.cfg_len = '0;
        chk("t3_stage_en_idle", 32'(bus.stage_en), 0);
        cyc();
        bus.start = 1'b0;
        chk("t3_out_valid", 32'(bus.out_valid), 1);
        chk("t3_out_acc",   32'(bus.out_acc),   0);
        chk("t3_stage_en",  32'(bus.stage_en),  0);
        cyc();
        chk("t3_busy_after", 32'(bus.busy),     0);
        chk("t3_stage_en_after", 32'(bus.stage_en), 0);

        // 4: bubbles between two operands, -7 + -9 = -16
        push(20'hFFFF0, 1'b0);
        start_job(2);
        pat     = '{1, 0, 0, 1};
        vals[0] = SUM_W'(-7);
        vals[1] = SUM_W'(1234);
        vals[2] = SUM_W'(4321);
        vals[3] = SUM_W'(-9);
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = (pat[i] != 0);
            op_val       = vals[i];
            chk("t4_in_ready_run", 32'(bus.in_ready), 1);
            cyc();
        end
        bus.in_valid = 1'b0;
        chk("t4_in_ready_drain", 32'(bus.in_ready), 0);
        wait_out(n);
        chk("t4_drain_cycles", 32'(n), 3);
        cyc();

        // 5: consumer stalls in HOLD; start is ignored and output stays stable
        bus.out_ready = 1'b0;
        push(ACC_W'(42), 1'b0);
        start_job(1);
        bus.in_valid = 1'b1;
        op_val       = SUM_W'(42);
        cyc();
        bus.in_valid = 1'b0;
        wait_out(n);
        chk("t5_drain_cycles", 32'(n), 3);
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_valid",    32'(bus.out_valid), 1);
            chk("t5_hold_acc",      32'(bus.out_acc),   32'h0002A);
            chk("t5_hold_stage_en", 32'(bus.stage_en),  0);
            chk("t5_hold_in_ready", 32'(bus.in_ready),  0);
            bus.start   = (i == 2);
            bus.cfg_len = '0;
            cyc();
        end
        bus.start = 1'b0;
        chk("t5_still_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        cyc();
        chk("t5_idle_busy",  32'(bus.busy),      0);
        chk("t5_idle_valid", 32'(bus.out_valid), 0);
        cyc();
        chk("t5_no_stray_job", 32'(bus.out_valid), 0);

        // 6: positive overflow, then negative overflow, then a clean job
`ifdef SD4_MAC_SAT_EN
        push(20'h7FFFF, 1'b1);
`else
        push(20'hFFFFE, 1'b0);
`endif
        start_job(2);
        bus.in_valid = 1'b1;
        op_val       = 20'h7FFFF;
        cyc();
        cyc();
        bus.in_valid = 1'b0;
        wait_out(n);
        chk("t6_drain_cycles", 32'(n), 3);
        cyc();

`ifdef SD4_MAC_SAT_EN
        push(20'h80000, 1'b1);
`else
        push(20'h00000, 1'b0);
`endif
        start_job(2);
        bus.in_valid = 1'b1;
        op_val       = 20'h80000;
        cyc();
        cyc();
        bus.in_valid = 1'b0;
        wait_out(n);
        cyc();

        push(ACC_W'(3), 1'b0);
        start_job(1);
`ifdef SD4_MAC_SAT_EN
        chk("t6_ovf_cleared", 32'(bus.out_ovf), 0);
`endif
        chk("t6_acc_cleared", 32'(bus.out_acc), 0);
        bus.in_valid = 1'b1;
        op_val       = SUM_W'(3);
        cyc();
        bus.in_valid = 1'b0;
        wait_out(n);
        cyc();
        cyc();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
